// File: rtl/membus_mem.sv
// Memory module on the memory bus: 16K x 36 array answering addressed read,
// write and read-modify-write cycles, with a fixed recovery gap between cycles.
module membus_mem #(
    parameter logic [3:0] MODSEL = 4'b0000,
    parameter int         RECOV  = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         rq_cyc,
    input  logic         rd_rq,
    input  logic         wr_rq,
    input  logic [21:35] ma,
    input  logic [18:21] sel,
    input  logic         fmc_select,
    input  logic [0:35]  mb_in,
    input  logic         wr_rs,
    output logic         addr_ack,
    output logic         rd_rs,
    output logic [0:35]  mb_out
);

    typedef enum logic [2:0] {
        IDLE, ACK, RD_FETCH, RD_RESP, WR_WAIT, WR_CAP, WR_COMMIT, RECOVER
    } state_t;

    localparam int RW = (RECOV < 2) ? 1 : $clog2(RECOV);

    state_t          state;
    logic [13:0]     addr_q;
    logic            rd_q;
    logic            wr_q;
    logic [0:35]     cap;
    logic [1:0]      cap_cnt;
    logic [RW-1:0]   rec_cnt;
    logic [0:35]     mem [0:16383];
    logic            selected;
    logic            unused_ma;

    assign selected  = rq_cyc & ~fmc_select & (sel == MODSEL) & (rd_rq | wr_rq);
    assign unused_ma = ma[21];

    // The array has no reset so its contents survive a bus reset; a write only
    // happens from WR_COMMIT, which reset leaves immediately.
    always_ff @(posedge clk) begin
        if (state == WR_COMMIT)
            mem[addr_q] <= cap;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            cap      <= '0;
            cap_cnt  <= '0;
            rec_cnt  <= '0;
            addr_ack <= 1'b0;
            rd_rs    <= 1'b0;
            mb_out   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (selected) begin
                        addr_q   <= ma[22:35];
                        rd_q     <= rd_rq;
                        wr_q     <= wr_rq;
                        addr_ack <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    if (!rq_cyc) begin
                        addr_ack <= 1'b0;
                        state    <= rd_q ? RD_FETCH : WR_WAIT;
                    end
                end
                RD_FETCH: begin
                    mb_out <= mem[addr_q];
                    rd_rs  <= 1'b1;
                    state  <= RD_RESP;
                end
                RD_RESP: begin
                    rd_rs <= 1'b0;
                    if (!rd_rq) begin
                        mb_out  <= '0;
                        rec_cnt <= '0;
                        state   <= wr_q ? WR_WAIT : ((RECOV == 0) ? IDLE : RECOVER);
                    end
                end
                // Data pulses are wired-OR and may trail wr_rs, so the capture
                // register accumulates over the restart cycle and three more.
                WR_WAIT: begin
                    if (wr_rs) begin
                        cap     <= mb_in;
                        cap_cnt <= '0;
                        state   <= WR_CAP;
                    end else if (!wr_rq) begin
                        cap     <= '0;
                        rec_cnt <= '0;
                        state   <= (RECOV == 0) ? IDLE : RECOVER;
                    end else begin
                        cap <= '0;
                    end
                end
                WR_CAP: begin
                    cap <= cap | mb_in;
                    if (cap_cnt == 2'd2)
                        state <= WR_COMMIT;
                    else
                        cap_cnt <= cap_cnt + 2'd1;
                end
                WR_COMMIT: begin
                    rec_cnt <= '0;
                    state   <= (RECOV == 0) ? IDLE : RECOVER;
                end
                RECOVER: begin
                    if (rec_cnt == RW'(RECOV - 1))
                        state <= IDLE;
                    else
                        rec_cnt <= rec_cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_membus_mem.sv
// Directed bench for membus_mem: bus-master tasks drive cycles, a model of the
// array feeds an expected-read queue that is popped when rd_rs appears.
module tb_membus_mem;

    localparam logic [3:0] MODSEL = 4'd3;
    localparam int         RECOV  = 2;

    logic         clk = 1'b0;
    logic         reset;
    logic         rq_cyc, rd_rq, wr_rq, fmc_select, wr_rs;
    logic [21:35] ma;
    logic [18:21] sel;
    logic [0:35]  mb_in;
    logic         addr_ack, rd_rs;
    logic [0:35]  mb_out;

    int          tests  = 0;
    int          failed = 0;
    int          lat;
    logic [35:0] exp_q [$];
    logic [35:0] model [int];

    always #5 clk = ~clk;

    membus_mem #(.MODSEL(MODSEL), .RECOV(RECOV)) dut (
        .clk(clk), .reset(reset), .rq_cyc(rq_cyc), .rd_rq(rd_rq), .wr_rq(wr_rq),
        .ma(ma), .sel(sel), .fmc_select(fmc_select), .mb_in(mb_in), .wr_rs(wr_rs),
        .addr_ack(addr_ack), .rd_rs(rd_rs), .mb_out(mb_out)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [35:0] obs, input logic [35:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0o required %0o", tag, obs, exp);
        end
    endtask

    task automatic start_cycle(input logic [13:0] addr, input logic rd, input logic wr);
        sel    = MODSEL;
        ma     = {1'b0, addr};
        rd_rq  = rd;
        wr_rq  = wr;
        rq_cyc = 1'b1;
    endtask

    task automatic wait_ack(input string tag, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!addr_ack && n < 20);
        check_output({tag, "_ack"}, 36'(addr_ack), 36'd1);
    endtask

    // Drop the request and scramble the address to show the latched one is used.
    task automatic end_ack(input string tag);
        rq_cyc = 1'b0;
        ma     = ~ma;
        tick();
        check_output({tag, "_ack_drop"}, 36'(addr_ack), 36'd0);
    endtask

    task automatic write_phase(input logic [13:0] addr, input logic [35:0] data, input int delay);
        tick();
        wr_rs = 1'b1;
        mb_in = (delay == 0) ? data : 36'd0;
        tick();
        wr_rs = 1'b0;
        mb_in = '0;
        wr_rq = 1'b0;
        if (delay > 0) begin
            repeat (delay - 1) tick();
            mb_in = data;
            tick();
            mb_in = '0;
        end
        model[int'(addr)] = data;
        repeat (6) tick();
    endtask

    task automatic read_phase(input string tag);
        int n;
        logic [35:0] exp;
        n = 0;
        do begin
            tick();
            n++;
        end while (!rd_rs && n < 20);
        check_output({tag, "_rd_rs"}, 36'(rd_rs), 36'd1);
        exp = exp_q.pop_front();
        check_output({tag, "_data"}, mb_out, exp);
        tick();
        check_output({tag, "_rd_rs_pulse"}, 36'(rd_rs), 36'd0);
        check_output({tag, "_hold"}, mb_out, exp);
        rd_rq = 1'b0;
        tick();
        check_output({tag, "_release"}, mb_out, 36'd0);
    endtask

    task automatic do_write(input logic [13:0] addr, input logic [35:0] data, input int delay,
                            input string tag, output int n);
        start_cycle(addr, 1'b0, 1'b1);
        wait_ack(tag, n);
        end_ack(tag);
        write_phase(addr, data, delay);
    endtask

    task automatic do_read(input logic [13:0] addr, input string tag, output int n);
        exp_q.push_back(model[int'(addr)]);
        start_cycle(addr, 1'b1, 1'b0);
        wait_ack(tag, n);
        end_ack(tag);
        read_phase(tag);
    endtask

    task automatic deselect_run(input string tag);
        logic any;
        any    = 1'b0;
        rq_cyc = 1'b1;
        rd_rq  = 1'b1;
        repeat (50) begin
            tick();
            any = any | addr_ack | rd_rs | (|mb_out);
        end
        check_output(tag, 36'(any), 36'd0);
        rq_cyc = 1'b0;
        rd_rq  = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        reset = 1'b0; rq_cyc = 1'b0; rd_rq = 1'b0; wr_rq = 1'b0; fmc_select = 1'b0;
        wr_rs = 1'b0; ma = '0; sel = '0; mb_in = '0;
        repeat (3) tick();
        check_output("reset_addr_ack", 36'(addr_ack), 36'd0);
        check_output("reset_rd_rs", 36'(rd_rs), 36'd0);
        check_output("reset_mb_out", mb_out, 36'd0);
        reset = 1'b1;
        tick();

        do_write(14'o12345, 36'o123456701234, 0, "wr1", lat);
        check_output("wr1_ack_latency", 36'(lat), 36'd1);
        do_read(14'o12345, "rd1", lat);

        do_write(14'o100, 36'o707070707070, 2, "wr_dly2", lat);
        do_read(14'o100, "rd_dly2", lat);
        do_write(14'o101, 36'o525252525252, 3, "wr_dly3", lat);
        do_read(14'o101, "rd_dly3", lat);

        sel = 4'd5;
        deselect_run("desel_sel5");
        sel = MODSEL;
        fmc_select = 1'b1;
        deselect_run("desel_fmc");
        fmc_select = 1'b0;
        do_read(14'o12345, "rd_after_desel", lat);
        check_output("desel_ack_latency", 36'(lat), 36'd1);

        do_write(14'o777, 36'o1, 0, "rmw_init", lat);
        exp_q.push_back(model[int'(14'o777)]);
        start_cycle(14'o777, 1'b1, 1'b1);
        wait_ack("rmw", lat);
        end_ack("rmw");
        read_phase("rmw_rd");
        check_output("rmw_single_ack", 36'(addr_ack), 36'd0);
        write_phase(14'o777, 36'o2, 0);
        do_read(14'o777, "rmw_check", lat);

        exp_q.push_back(model[int'(14'o12345)]);
        start_cycle(14'o12345, 1'b1, 1'b0);
        wait_ack("b2b_rd", lat);
        end_ack("b2b_rd");
        read_phase("b2b_rd");
        start_cycle(14'o200, 1'b0, 1'b1);
        wait_ack("b2b_wr", lat);
        check_output("b2b_recov_delay", 36'(lat), 36'(RECOV + 1));
        end_ack("b2b_wr");
        write_phase(14'o200, 36'o333333333333, 0);
        do_read(14'o200, "b2b_check", lat);

        // Reset while the write data is being captured.
        start_cycle(14'o12345, 1'b0, 1'b1);
        wait_ack("rst_wr", lat);
        end_ack("rst_wr");
        tick();
        wr_rs = 1'b1;
        mb_in = '1;
        tick();
        wr_rs = 1'b0;
        mb_in = '0;
        tick();
        #2 reset = 1'b0;
        #1;
        check_output("rst_wrcap_addr_ack", 36'(addr_ack), 36'd0);
        check_output("rst_wrcap_rd_rs", 36'(rd_rs), 36'd0);
        check_output("rst_wrcap_mb_out", mb_out, 36'd0);
        wr_rq = 1'b0;
        tick();
        tick();
        #2 reset = 1'b1;
        tick();
        do_read(14'o12345, "rst_wr_preserved", lat);
        check_output("post_reset_ack_latency", 36'(lat), 36'd1);

        // Reset while read data is on the bus clears it without a clock.
        start_cycle(14'o100, 1'b1, 1'b0);
        wait_ack("rst_rd", lat);
        end_ack("rst_rd");
        tick();
        check_output("rst_rd_data", mb_out, model[int'(14'o100)]);
        #2 reset = 1'b0;
        #1;
        check_output("rst_rd_mb_out", mb_out, 36'd0);
        check_output("rst_rd_rd_rs", 36'(rd_rs), 36'd0);
        rd_rq = 1'b0;
        tick();
        #2 reset = 1'b1;
        tick();
        do_read(14'o100, "rst_rd_after", lat);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
